// File: rtl/rtc_bus_initiator.sv
// rtc_bus_initiator: runs one address/data-strobe bus cycle to the RTC per request.
// Optional RD_DOUBLE_SAMPLE_EN adds rd_err_o, set when the last two ACCESS samples differ.
module rtc_bus_initiator #(
  parameter int T_AS  = 4,
  parameter int T_GAP = 2,
  parameter int T_ACC = 7,
  parameter int T_REC = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       wr_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] ad_i,
  output logic [7:0] ad_o,
  output logic       ad_oe_o,
  output logic       cs_n_o,
  output logic       as_n_o,
  output logic       rd_n_o,
  output logic       wr_n_o,
  output logic [7:0] rdata_o,
  output logic       busy_o,
  output logic       done_o
`ifdef RD_DOUBLE_SAMPLE_EN
  ,
  output logic       rd_err_o
`endif
);
  typedef enum logic [2:0] {IDLE, ADDR, GAP, ACCESS, RECOVER, DONE} state_t;
  state_t     state, nxt;
  logic [3:0] cnt;
  logic       last;
  logic       wr_l;
  logic [7:0] wdata_l;
  always_comb begin
    nxt  = state;
    last = 1'b0;
    case (state)
      IDLE:    nxt = start_i ? ADDR : IDLE;
      ADDR:    begin last = cnt == 4'(T_AS - 1);  nxt = last ? GAP : ADDR; end
      GAP:     begin last = cnt == 4'(T_GAP - 1); nxt = last ? ACCESS : GAP; end
      ACCESS:  begin last = cnt == 4'(T_ACC - 1); nxt = last ? RECOVER : ACCESS; end
      RECOVER: begin last = cnt == 4'(T_REC - 1); nxt = last ? DONE : RECOVER; end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state || state == IDLE) ? '0 : cnt + 4'd1;
    end
  end
  // Bus outputs are decoded from the next state so they change on the clock edge only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_l    <= 1'b0;
      wdata_l <= '0;
      cs_n_o  <= 1'b1;
      as_n_o  <= 1'b1;
      rd_n_o  <= 1'b1;
      wr_n_o  <= 1'b1;
      ad_oe_o <= 1'b0;
      ad_o    <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      rdata_o <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        wr_l    <= wr_i;
        wdata_l <= wdata_i;
      end
      cs_n_o  <= !(nxt == ADDR || nxt == GAP || nxt == ACCESS);
      as_n_o  <= nxt != ADDR;
      rd_n_o  <= !(nxt == ACCESS && !wr_l);
      wr_n_o  <= !(nxt == ACCESS && wr_l);
      ad_oe_o <= nxt == ADDR || (wr_l && (nxt == GAP || nxt == ACCESS));
      ad_o    <= (state == IDLE && start_i) ? addr_i :
                 (state == ADDR && nxt == GAP && wr_l) ? wdata_l : ad_o;
      busy_o  <= nxt != IDLE;
      done_o  <= nxt == DONE;
      if (state == ACCESS && last && !wr_l) rdata_o <= ad_i;
    end
  end
`ifdef RD_DOUBLE_SAMPLE_EN
  logic [7:0] early;
  logic       mism;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      early    <= '0;
      mism     <= 1'b0;
      rd_err_o <= 1'b0;
    end else begin
      if (state == ACCESS && cnt == 4'(T_ACC - 2)) early <= ad_i;
      if (state == ACCESS && last) mism <= !wr_l && (early != ad_i);
      rd_err_o <= nxt == DONE && mism;
    end
  end
`endif
endmodule

// File: tb/tb_rtc_bus_initiator.sv
// tb_rtc_bus_initiator: randomized self-checking bench; expected bus waveforms come from phase boundaries.
`timescale 1ns/1ps
module tb_rtc_bus_initiator;
  localparam int A = 4, G = 2, C = 7, R = 3;
  localparam int E_A = A, E_G = A + G, E_C = A + G + C, E_D = A + G + C + R + 1;
  logic       clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, wr_i = 1'b0;
  logic [7:0] addr_i = '0, wdata_i = '0, ad_i = '0;
  logic [7:0] ad_o, rdata_o;
  logic       ad_oe_o, cs_n_o, as_n_o, rd_n_o, wr_n_o, busy_o, done_o;
`ifdef RD_DOUBLE_SAMPLE_EN
  logic       rd_err_o;
`endif
  int         errors = 0, checks = 0;
  logic [7:0] exp_rdata = '0;

  rtc_bus_initiator dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .wr_i(wr_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ad_i(ad_i), .ad_o(ad_o),
    .ad_oe_o(ad_oe_o), .cs_n_o(cs_n_o), .as_n_o(as_n_o), .rd_n_o(rd_n_o),
    .wr_n_o(wr_n_o), .rdata_o(rdata_o), .busy_o(busy_o), .done_o(done_o)
`ifdef RD_DOUBLE_SAMPLE_EN
    , .rd_err_o(rd_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic test_reset;
    rst_ni = 1'b0;
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({cs_n_o, as_n_o, rd_n_o, wr_n_o, ad_oe_o, busy_o, done_o} !== 7'b1111000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1111000", {cs_n_o, as_n_o, rd_n_o, wr_n_o, ad_oe_o, busy_o, done_o});
    end
    checks++;
    if (ad_o !== 8'h00 || rdata_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got ad_o=%h rdata=%h want 00/00", ad_o, rdata_o);
    end
    rst_ni = 1'b1;
    exp_rdata = '0;
    @(negedge clk_i);
  endtask

  task automatic test_idle;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      checks++;
      if ({cs_n_o, as_n_o, rd_n_o, wr_n_o, ad_oe_o, busy_o, done_o} !== 7'b1111000) begin
        errors++;
        $display("FAIL idle_ctrl cyc=%0d got %b want 1111000", i, {cs_n_o, as_n_o, rd_n_o, wr_n_o, ad_oe_o, busy_o, done_o});
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after DONE.
  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] early, input logic [7:0] fin, input logic poke, input logic hold);
    wr_i = wr;
    addr_i = addr;
    wdata_i = wdata;
    start_i = 1'b1;
    ad_i = 8'($urandom);
    for (int t = 1; t <= E_D + 1; t++) begin
      logic pa, pg, pc, pd;
      logic [6:0] exp_ctrl;
      logic [7:0] exp_ad;
      @(negedge clk_i);
      pa = t <= E_A;
      pg = t > E_A && t <= E_G;
      pc = t > E_G && t <= E_C;
      pd = t == E_D;
      exp_ctrl = {!(pa || pg || pc), !pa, !(pc && !wr), !(pc && wr),
                  pa || (wr && (pg || pc)), 1'(t <= E_D), pd};
      checks++;
      if ({cs_n_o, as_n_o, rd_n_o, wr_n_o, ad_oe_o, busy_o, done_o} !== exp_ctrl) begin
        errors++;
        $display("FAIL txn_ctrl wr=%0d t=%0d got %b want %b", wr, t,
                 {cs_n_o, as_n_o, rd_n_o, wr_n_o, ad_oe_o, busy_o, done_o}, exp_ctrl);
      end
      if (pa || pg || (pc && wr)) begin
        exp_ad = (pa || (pg && !wr)) ? addr : wdata;
        checks++;
        if (ad_o !== exp_ad) begin
          errors++;
          $display("FAIL txn_ad wr=%0d t=%0d got %h want %h", wr, t, ad_o, exp_ad);
        end
      end
      if (t == E_C + 1) begin
        if (!wr) exp_rdata = fin;
        checks++;
        if (rdata_o !== exp_rdata) begin
          errors++;
          $display("FAIL txn_rdata wr=%0d got %h want %h", wr, rdata_o, exp_rdata);
        end
      end
`ifdef RD_DOUBLE_SAMPLE_EN
      checks++;
      if (rd_err_o !== (pd && !wr && early != fin)) begin
        errors++;
        $display("FAIL txn_rd_err t=%0d got %b want %b", t, rd_err_o, pd && !wr && early != fin);
      end
`endif
      start_i = (pd && hold) || (poke && (t == 2 || t == E_G + 3 || pd));
      if (poke) begin
        wr_i = 1'($urandom);
        addr_i = 8'($urandom);
        wdata_i = 8'($urandom);
      end
      ad_i = pc ? ((t == E_C) ? fin : early) : 8'($urandom);
      if (t == E_D + 1) start_i = hold;
    end
  endtask

  task automatic test_read;
    run_txn(1'b0, 8'h21, 8'hA5, 8'h5A, 8'h5A, 1'b0, 1'b0);
  endtask

  task automatic test_write;
    run_txn(1'b1, 8'h10, 8'h3C, 8'hEE, 8'h77, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start;
    run_txn(1'b0, 8'h42, 8'h00, 8'h99, 8'h99, 1'b1, 1'b0);
    run_txn(1'b1, 8'h43, 8'hC3, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_txn(1'b1, 8'h01, 8'h81, 8'h00, 8'h00, 1'b0, 1'b1);
    run_txn(1'b0, 8'h02, 8'h00, 8'h6B, 8'h6B, 1'b0, 1'b1);
    run_txn(1'b0, 8'h03, 8'h00, 8'hB6, 8'hB6, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    wr_i = 1'b0;
    addr_i = 8'h55;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (E_G + 2) @(negedge clk_i);
    checks++;
    if (rd_n_o !== 1'b0 || cs_n_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_access got rd_n=%b cs_n=%b want 0/0", rd_n_o, cs_n_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({rd_n_o, cs_n_o, busy_o, ad_oe_o, done_o} !== 5'b11000) begin
      errors++;
      $display("FAIL async_reset got %b want 11000", {rd_n_o, cs_n_o, busy_o, ad_oe_o, done_o});
    end
    exp_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got done=%b busy=%b want 0/0", i, done_o, busy_o);
      end
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || rdata_o !== 8'h00) begin
      errors++;
      $display("FAIL after_release got done=%b busy=%b rdata=%h want 0/0/00", done_o, busy_o, rdata_o);
    end
    run_txn(1'b0, 8'h66, 8'h00, 8'hD2, 8'hD2, 1'b0, 1'b0);
  endtask

  task automatic test_double_sample;
    run_txn(1'b0, 8'h30, 8'h00, 8'h11, 8'h22, 1'b0, 1'b0);
    run_txn(1'b0, 8'h31, 8'h00, 8'h44, 8'h44, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e, f;
      e = 8'($urandom);
      f = ($urandom_range(0, 1) == 0) ? e : 8'($urandom);
      run_txn(1'($urandom), 8'($urandom), 8'($urandom), e, f,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    start_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    test_reset;
    test_idle;
    test_read;
    test_write;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_double_sample;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rtc_bus_initiator.md
Name: rtc_bus_initiator

Overview:
- Master side of the multiplexed address/data strobe bus to the RTC device; the counterpart of the delayed-strobe responder used on that bus.
- Takes a one-cycle request from the controller FSM and runs one complete bus cycle: address phase, turnaround, timed access (tacc) window, recovery.
- Captures read data at the end of the access window and returns a one-cycle done.
- All bus outputs are registered, so strobes are glitch-free.

Parameters:
- T_AS, 4, cycles the address strobe is held low (1..15)
- T_GAP, 2, cycles between address strobe release and the rd/wr strobe (1..15)
- T_ACC, 7, cycles rd_n/wr_n is held low, i.e. the tacc window (2..15)
- T_REC, 3, cycles of recovery with the chip deselected before done (1..15)

Ports:
- clk_i, in, 1, system clock, rising edge
- rst_ni, in, 1, asynchronous active-low reset
- start_i, in, 1, request pulse; sampled only in IDLE
- wr_i, in, 1, 1 = write cycle, 0 = read cycle; latched with start_i
- addr_i, in, 8, register address; latched with start_i
- wdata_i, in, 8, write data; latched with start_i
- ad_i, in, 8, bus AD lines, read path
- ad_o, out, 8, bus AD lines, drive path
- ad_oe_o, out, 1, AD output enable, 1 = drive
- cs_n_o, out, 1, chip select, active low
- as_n_o, out, 1, address strobe, active low
- rd_n_o, out, 1, read strobe, active low
- wr_n_o, out, 1, write strobe, active low
- rdata_o, out, 8, last captured read data
- busy_o, out, 1, high in every state except IDLE
- done_o, out, 1, one-cycle completion pulse

Behaviour:
- Reset (async assert, synchronous release effect):
  - State IDLE.
  - cs_n_o, as_n_o, rd_n_o, wr_n_o = 1.
  - ad_oe_o, ad_o, rdata_o, busy_o, done_o = 0.
  - Phase counter = 0. Latched wr, addr, wdata = 0.
- Reset mid-cycle: all outputs return to reset values immediately (asynchronously). No done is issued.
- Phase counter: 4 bits. It is cleared on every state entry and compared against (T_x - 1) to leave the phase.
- IDLE:
  - start_i = 1 at edge k latches wr_i, addr_i, wdata_i and enters ADDR.
  - start_i is ignored in every other state; no queuing.
- ADDR (T_AS cycles): cs_n_o = 0, as_n_o = 0, ad_oe_o = 1, ad_o = addr.
- GAP (T_GAP cycles): as_n_o = 1, cs_n_o = 0.
  - Write: ad_oe_o = 1, ad_o = wdata.
  - Read: ad_oe_o = 0 (bus turnaround); ad_o holds addr.
- ACCESS (T_ACC cycles): cs_n_o = 0.
  - Read: rd_n_o = 0, ad_oe_o = 0.
  - Write: wr_n_o = 0, ad_oe_o = 1, ad_o = wdata.
  - rd_n_o and wr_n_o are never low together.
- Read capture: rdata_o <= ad_i on the clock edge that ends the last ACCESS cycle. rdata_o is unchanged by writes and holds until the next read.
- RECOVER (T_REC cycles): cs_n_o = 1, all strobes = 1, ad_oe_o = 0.
- DONE (1 cycle): done_o = 1, busy_o = 1, then IDLE.
- Latency: done_o is high in the cycle following edge k + T_AS + T_GAP + T_ACC + T_REC. With defaults, done is 16 cycles after acceptance.
- Back-to-back: start_i held high through DONE is taken on the first IDLE cycle, giving a minimum of one IDLE cycle between bus cycles.
- busy_o is 1 from the cycle after acceptance through DONE inclusive.

Optional Feature:
- Macro: RD_DOUBLE_SAMPLE_EN.
- When defined:
  - Adds output rd_err_o (1 bit).
  - On reads, ad_i is also sampled at the edge ending the second-to-last ACCESS cycle.
  - If that sample differs from the final sample, rd_err_o = 1 during the DONE cycle. rd_err_o is 0 otherwise and 0 at reset.
  - rdata_o always takes the final sample.
- When not defined: rd_err_o does not exist; only the single final sample is taken.

Test Plan:
1. Reset then idle 20 cycles, start_i = 0 -> cs_n/as_n/rd_n/wr_n = 1, ad_oe = 0, busy = 0, done = 0 throughout.
2. Read, addr = 0x21, ad_i = 0x5A during ACCESS, default params:
   - as_n low 4 cycles with ad_o = 0x21, ad_oe = 1.
   - Then 2 gap cycles with ad_oe = 0.
   - Then rd_n low exactly 7 cycles.
   - rdata_o = 0x5A; done pulse 16 cycles after the accept edge.
3. Write, addr = 0x10, wdata = 0x3C:
   - ad_o = 0x3C with ad_oe = 1 through GAP and all 7 wr_n-low cycles.
   - rd_n stays 1; rdata_o unchanged from its prior value.
4. start_i pulsed while busy (ADDR, ACCESS, DONE) -> ignored; exactly one done. start_i held high -> next ADDR begins after one IDLE cycle.
5. rst_ni asserted during ACCESS -> rd_n, cs_n go to 1 and busy to 0 without waiting for a clock; no done. A new request after release completes normally.
6. With RD_DOUBLE_SAMPLE_EN: ad_i changes 0x11 -> 0x22 on the final ACCESS cycle -> rdata_o = 0x22, rd_err_o = 1 in the DONE cycle. Stable ad_i -> rd_err_o = 0.
